// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding,
// default frame timeout and a small one-hot helper.
package uart_tx_arbiter_pkg;

  // Default number of cycles to wait for tx_done before giving up on a frame.
  localparam int unsigned DEFAULT_TIMEOUT = 8192;

  // Transaction phases of the arbiter; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  // One-hot decode of a 2-bit source index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick4.sv
// Round-robin picker for four requesters: scans upward from the slot after
// last_ptr, wrapping at 3, and returns the first requesting index.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_ptr_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // First set request bit at offsets 1..4 from last_ptr (offset 4 is last_ptr itself).
  always_comb begin
    found_o = 1'b0;
    idx_o   = last_ptr_i;
    cand    = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr_i + 2'(i);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between four byte sources.
//
// Handshakes:
//  - Source side: req_i[i] acts as "valid" for the byte on mux input i. The
//    arbiter samples req_i only in IDLE; once a winner is chosen its byte is
//    owned by the arbiter and ack_o[i] pulses for one cycle when it has been
//    consumed (sent or abandoned on timeout). A req still high in the IDLE
//    cycle after ack is treated as a fresh byte.
//  - TX side: tx_start_o pulses one cycle to load and send the byte selected
//    by sel_o; tx_done_i is honoured only while waiting for that frame.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       tx_done_i,
  output logic [1:0] sel_o,
  output logic [3:0] grant_o,
  output logic       tx_start_o,
  output logic [3:0] ack_o,
  output logic       busy_o,
  output logic       err_timeout_o,
  output arb_state_e state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  arb_state_e    state_q;
  logic [1:0]    sel_q;
  logic [3:0]    grant_q;
  logic          busy_q;
  logic [1:0]    last_ptr_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  logic          pick_found;
  logic [1:0]    pick_idx;
  logic          wait_expired;

  rr_pick4 u_pick (
    .req_i      (req_i),
    .last_ptr_i (last_ptr_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  // Saturating increment so the wait timer can never wrap back to zero.
  always_comb begin
    timer_d = timer_q;
    if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign wait_expired = (state_q == ST_WAIT) && (timer_q == TIMER_LAST);

  // Transaction sequencer: arbitrate, settle mux, start frame, wait, acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      last_ptr_q <= 2'd3;
      timer_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            grant_q <= onehot4(pick_idx);
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          state_q <= ST_START;
        end
        ST_START: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          timer_q <= timer_d;
          // A done arriving on the last timer cycle still counts as success.
          if (tx_done_i || wait_expired) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_ptr_q <= sel_q;
          grant_q    <= 4'b0000;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          grant_q <= 4'b0000;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Pulsed outputs decode directly from the current phase.
  assign tx_start_o    = (state_q == ST_START);
  assign ack_o         = (state_q == ST_DONE) ? onehot4(sel_q) : 4'b0000;
  assign err_timeout_o = wait_expired && !tx_done_i;

  assign sel_o   = sel_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       tx_done = 1'b0;
  logic [1:0] sel_o;
  logic [3:0] grant_o;
  logic       tx_start_o;
  logic [3:0] ack_o;
  logic       busy_o;
  logic       err_timeout_o;
  arb_state_e state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  uart_tx_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .tx_done_i     (tx_done),
    .sel_o         (sel_o),
    .grant_o       (grant_o),
    .tx_start_o    (tx_start_o),
    .ack_o         (ack_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o),
    .state_o       (state_o)
  );

  // ---------------- reference model ----------------
  // A transaction starts at the end of an idle cycle with any request; the
  // output timeline is then expressed as offsets from that cycle.
  bit         m_active;
  bit         m_ack_now;
  int         m_k;
  logic [1:0] m_w;
  logic [1:0] m_last;
  logic [1:0] m_sel;

  function automatic logic [1:0] ref_pick(input logic [3:0] r, input logic [1:0] last);
    int idx;
    for (int i = 1; i <= 4; i++) begin
      idx = (int'(last) + i) % 4;
      if (r[idx]) return 2'(idx);
    end
    return last;
  endfunction

  // Expected {sel, grant, tx_start, ack, busy, err_timeout} for the current cycle.
  function automatic logic [12:0] model_expect(input logic d);
    logic [3:0] oh;
    oh = 4'b0001 << m_w;
    if (!m_active) return {m_sel, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    return {m_w, oh, (m_k == 2), (m_ack_now ? oh : 4'b0000), 1'b1,
            (!m_ack_now && (m_k == 2 + TO) && !d)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_ack_now = 0; m_k = 0; m_w = 2'd0; m_last = 2'd3; m_sel = 2'd0;
  endtask

  // Advance the model across one rising edge with inputs r/d.
  task automatic model_update(input logic [3:0] r, input logic d);
    if (!m_active) begin
      if (r != 4'b0000) begin
        m_w = ref_pick(r, m_last); m_sel = m_w; m_active = 1; m_k = 1; m_ack_now = 0;
      end
    end else if (m_ack_now) begin
      m_active = 0; m_last = m_w; m_ack_now = 0;
    end else begin
      if (m_k >= 3 && (d || m_k == 2 + TO)) m_ack_now = 1;
      m_k++;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs just after a rising edge, sample mid-cycle, then step the model.
  task automatic cycle(input logic [3:0] r, input logic d);
    logic [12:0] exp_v;
    @(posedge clk);
    #1;
    req = r; tx_done = d; cyc++;
    @(negedge clk);
    exp_v = model_expect(d);
    chk("model", {sel_o, grant_o, tx_start_o, ack_o, busy_o, err_timeout_o}, exp_v);
    model_update(r, d);
  endtask

  task automatic reset_dut(input logic [3:0] r_hold);
    req = r_hold; tx_done = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sel_o, grant_o, tx_start_o, ack_o, busy_o, err_timeout_o}, 13'd0);
    rst_n = 1'b1;
    model_reset();
    model_update(r_hold, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       ts;
    logic [3:0] ack;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int s, e, ack_cyc, cd;
    logic [3:0] ack_e1, grant_e3;
    bit err_seen;
    logic [1:0] exp_q[$];
    logic [1:0] exp_idx;
    logic [3:0] r;
    logic d;

    //            req      done  sel   grant    ts    ack      busy  err
    vecs[0]  = '{4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{4'b1000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 2'd3, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[13] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0};
    vecs[15] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    // Reset with all requests high; source 0 wins first after release.
    reset_dut(4'hF);
    cycle(4'h0, 1'b0);
    chk("reset_release_grant", {sel_o, grant_o}, {2'd0, 4'b0001});
    repeat (12) cycle(4'h0, 1'b0);

    // Directed table: single requester, stray done in IDLE, immediate done.
    reset_dut(4'h0);
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), {sel_o, grant_o, tx_start_o, ack_o, busy_o, err_timeout_o},
          {vecs[i].sel, vecs[i].grant, vecs[i].ts, vecs[i].ack, vecs[i].busy, vecs[i].err});
    end

    // All four requesting, done three cycles after each start: strict rotation.
    reset_dut(4'h0);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    cd = 0;
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
      d = (cd == 1);
      if (cd > 0) cd--;
      cycle(4'hF, d);
      if (tx_start_o) cd = 3;
      if (ack_o != 4'b0000) begin
        exp_idx = exp_q.pop_front();
        chk("rr_ack_order", ack_o, 4'b0001 << exp_idx);
      end
    end
    chk("rr_all_acked", exp_q.size(), 0);

    // Timeout with no done; next requester gets the following grant.
    reset_dut(4'h0);
    s = -1; e = -1; ack_e1 = 4'b0000; grant_e3 = 4'b0000;
    for (int n = 0; n < 30; n++) begin
      cycle(4'b0011, 1'b0);
      if (tx_start_o && s < 0) s = cyc;
      if (err_timeout_o && e < 0) e = cyc;
      if (e >= 0 && cyc == e + 1) ack_e1 = ack_o;
      if (e >= 0 && cyc == e + 3) grant_e3 = grant_o;
    end
    chk("timeout_latency", e - s, TO);
    chk("timeout_ack", ack_e1, 4'b0001);
    chk("timeout_next_grant", grant_e3, 4'b0010);

    // Done on the last timer cycle is a success, not a timeout.
    reset_dut(4'h0);
    s = -1; ack_cyc = -1; err_seen = 0;
    cycle(4'b0100, 1'b0);
    for (int n = 0; n < 25; n++) begin
      d = (s >= 0) && (cyc + 1 == s + TO);
      cycle(4'h0, d);
      if (tx_start_o && s < 0) s = cyc;
      if (err_timeout_o) err_seen = 1;
      if (ack_o != 4'b0000 && ack_cyc < 0) ack_cyc = cyc;
    end
    chk("edge_done_no_err", err_seen, 0);
    chk("edge_done_ack_latency", ack_cyc - s, TO + 1);
    for (int n = 0; n < 3; n++) begin
      cycle(4'h0, 1'b1);
      chk("stray_done_idle", {busy_o, grant_o, tx_start_o, ack_o}, 10'd0);
    end

    // Asynchronous reset while waiting for a frame.
    reset_dut(4'h0);
    cycle(4'b0001, 1'b0);
    repeat (4) cycle(4'h0, 1'b0);
    chk("wait_before_reset", state_o, ST_WAIT);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sel_o, grant_o, tx_start_o, ack_o, busy_o, err_timeout_o}, 13'd0);
    chk("async_reset_state", state_o, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_update(4'h0, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'h0, 1'b0);
    chk("post_reset_sel3", sel_o, 2'd3);

    // Randomized traffic against the model.
    repeat (8) cycle(4'h0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'h0;
      d = ($urandom_range(0, 5) == 0);
      cycle(r, d);
    end
    // Sparse done pulses so timeouts occur regularly.
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 40) == 0);
      cycle(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
